// File: rtl/dsp_post_adder_acc.sv
// Purpose : DSP48A1 post-adder/subtracter and P output stage (Z +/- (X + CIN)), with P feedback for MAC.
// Latency : PREG=1 -> 1 clk (P, CARRYOUT registered under cep); PREG=0 -> 0 clk (combinational).
// Backpr. : none; cep=0 freezes the P stage, and there is no valid/ready handshake.
//
// Ports:
//   clk, rst (async, active-low), cep (P-stage clock enable)
//   x_in, c_in, pcin [WIDTH]  : X operand, C operand, cascade input
//   opmode_z [2]              : Z select 0=zero 1=pcin 2=P feedback 3=c_in
//   sub, carryin              : 0 -> Z+X+CIN, 1 -> Z-(X+CIN)
//   p, pcout [WIDTH], carryout: result, cascade copy of p, bit WIDTH of the sum
//   pattern_detect            : (next p == PATTERN), present only with DSP_PATTERN_DETECT_EN
// Optional feature macro: DSP_PATTERN_DETECT_EN
module dsp_post_adder_acc #(
    parameter int                 PREG    = 1,
    parameter int                 WIDTH   = 48,
    parameter logic [WIDTH-1:0]   PATTERN = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cep,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] pcin,
    input  logic [1:0]       opmode_z,
    input  logic             sub,
    input  logic             carryin,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] pcout,
    output logic             carryout
`ifdef DSP_PATTERN_DETECT_EN
    ,
    output logic             pattern_detect
`endif
);

    logic [WIDTH-1:0] w_p_fb;   // P value seen by the Z mux when opmode_z = 2
    logic [WIDTH-1:0] w_z;
    logic [WIDTH:0]   w_sum;
    logic             w_pd;

    always_comb begin
        w_z = '0;
        case (opmode_z)
            2'd0:    w_z = '0;
            2'd1:    w_z = pcin;
            2'd2:    w_z = w_p_fb;
            default: w_z = c_in;
        endcase
    end

    // Zero-extended to WIDTH+1 so bit WIDTH is the carry (add) or borrow (subtract).
    always_comb begin
        if (sub) begin
            w_sum = {1'b0, w_z} - {1'b0, x_in} - {{WIDTH{1'b0}}, carryin};
        end else begin
            w_sum = {1'b0, w_z} + {1'b0, x_in} + {{WIDTH{1'b0}}, carryin};
        end
    end

    assign w_pd = (w_sum[WIDTH-1:0] == PATTERN);

    generate
        if (PREG != 0) begin : g_preg
            logic [WIDTH-1:0] r_p;
            logic             r_co;
            logic             r_pd;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_p  <= '0;
                    r_co <= 1'b0;
                    r_pd <= 1'b0;
                end else if (cep) begin
                    r_p  <= w_sum[WIDTH-1:0];
                    r_co <= w_sum[WIDTH];
                    r_pd <= w_pd;
                end
            end

            assign p        = r_p;
            assign carryout = r_co;
            assign w_p_fb   = r_p;
`ifdef DSP_PATTERN_DETECT_EN
            assign pattern_detect = r_pd;
`else
            wire w_unused_pd = r_pd;
`endif
        end else begin : g_comb
            // Without a P register, feedback would be a combinational loop, so Z=2 selects zero.
            assign w_p_fb   = '0;
            assign p        = rst ? w_sum[WIDTH-1:0] : '0;
            assign carryout = rst ? w_sum[WIDTH]     : 1'b0;
`ifdef DSP_PATTERN_DETECT_EN
            assign pattern_detect = rst ? w_pd : 1'b0;
`else
            wire w_unused_pd = w_pd;
`endif
            wire w_unused_clk = clk ^ cep;
        end
    endgenerate

    assign pcout = p;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Purpose : scoreboard bench for dsp_post_adder_acc (PREG=1 and PREG=0 instances).
// Latency : expectations pushed at the negedge are popped one posedge later.
// Backpr. : none.
module tb_dsp_post_adder_acc;
    localparam int W = 48;
    localparam logic [W-1:0] PAT1 = 48'd12;
    localparam logic [W-1:0] PAT0 = 48'd121;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // PREG = 1 instance
    logic         rst, cep, sub, carryin;
    logic [1:0]   opmode_z;
    logic [W-1:0] x_in, c_in, pcin;
    logic [W-1:0] p, pcout;
    logic         carryout;
    // PREG = 0 instance
    logic         rst0, cep0, sub0, carryin0;
    logic [1:0]   opmode_z0;
    logic [W-1:0] x_in0, c_in0, pcin0;
    logic [W-1:0] p0, pcout0;
    logic         carryout0;
`ifdef DSP_PATTERN_DETECT_EN
    logic         pd1, pd0;
`endif

    dsp_post_adder_acc #(.PREG(1), .WIDTH(W), .PATTERN(PAT1)) dut1 (
        .clk(clk), .rst(rst), .cep(cep), .x_in(x_in), .c_in(c_in), .pcin(pcin),
        .opmode_z(opmode_z), .sub(sub), .carryin(carryin),
        .p(p), .pcout(pcout), .carryout(carryout)
`ifdef DSP_PATTERN_DETECT_EN
        , .pattern_detect(pd1)
`endif
    );

    dsp_post_adder_acc #(.PREG(0), .WIDTH(W), .PATTERN(PAT0)) dut0 (
        .clk(clk), .rst(rst0), .cep(cep0), .x_in(x_in0), .c_in(c_in0), .pcin(pcin0),
        .opmode_z(opmode_z0), .sub(sub0), .carryin(carryin0),
        .p(p0), .pcout(pcout0), .carryout(carryout0)
`ifdef DSP_PATTERN_DETECT_EN
        , .pattern_detect(pd0)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] p;
        logic         co;
        logic         pd;
    } exp_t;
    exp_t q[$];
    exp_t e;

    // Reference model state for the registered instance
    logic [W-1:0] m_p  = '0;
    logic         m_co = 1'b0;
    logic         m_pd = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, req, $time);
        end
    endtask

    // Plain arithmetic: 64-bit two's complement, low 48 bits = p, bit 48 = carry/borrow.
    function automatic logic [63:0] ref_sum(input logic [W-1:0] z, input logic [W-1:0] x,
                                            input logic cin, input logic sb);
        logic [63:0] zz, xx, cc;
        zz = {16'h0, z};
        xx = {16'h0, x};
        cc = {63'h0, cin};
        return sb ? (zz - xx - cc) : (zz + xx + cc);
    endfunction

    function automatic logic [W-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0:       return {W{1'b1}};
            1:       return {40'h0, t[7:0]};
            default: return t[W-1:0];
        endcase
    endfunction

    // Drive one cycle of the registered instance and predict its state after the next edge.
    task automatic apply(input logic r, input logic ce, input logic [1:0] z, input logic [W-1:0] x,
                         input logic [W-1:0] c, input logic [W-1:0] pc, input logic cin,
                         input logic sb, input bit pulse);
        logic [W-1:0] zv;
        logic [63:0]  s;
        @(negedge clk);
        if (pulse) begin
            #1 rst = 1'b0;
            #1;
            check("async_rst_p", p, '0);
            check("async_rst_pcout", pcout, '0);
            check("async_rst_co", {47'h0, carryout}, '0);
            #2 rst = 1'b1;
            m_p = '0; m_co = 1'b0; m_pd = 1'b0;
        end
        rst = r; cep = ce; opmode_z = z; x_in = x; c_in = c; pcin = pc; carryin = cin; sub = sb;
        if (!r) begin
            m_p = '0; m_co = 1'b0; m_pd = 1'b0;
        end else if (ce) begin
            case (z)
                2'd0:    zv = '0;
                2'd1:    zv = pc;
                2'd2:    zv = m_p;
                default: zv = c;
            endcase
            s    = ref_sum(zv, x, cin, sb);
            m_p  = s[W-1:0];
            m_co = s[W];
            m_pd = (m_p == PAT1);
        end
        q.push_back('{p: m_p, co: m_co, pd: m_pd});
    endtask

    // Monitor: one expectation retires per rising edge, sampled after the edge settles.
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("p", p, e.p);
            check("pcout", pcout, e.p);
            check("carryout", {47'h0, carryout}, {47'h0, e.co});
`ifdef DSP_PATTERN_DETECT_EN
            check("pattern_detect", {47'h0, pd1}, {47'h0, e.pd});
`endif
        end
    end

    // Combinational instance: apply and compare immediately.
    task automatic comb(input logic r, input logic [1:0] z, input logic [W-1:0] x,
                        input logic [W-1:0] c, input logic [W-1:0] pc, input logic cin,
                        input logic sb);
        logic [W-1:0] zv, ep;
        logic [63:0]  s;
        logic         eco;
        rst0 = r; opmode_z0 = z; x_in0 = x; c_in0 = c; pcin0 = pc; carryin0 = cin; sub0 = sb;
        #1;
        case (z)
            2'd1:    zv = pc;
            2'd3:    zv = c;
            default: zv = '0;
        endcase
        s   = ref_sum(zv, x, cin, sb);
        ep  = r ? s[W-1:0] : '0;
        eco = r ? s[W] : 1'b0;
        check("p0", p0, ep);
        check("pcout0", pcout0, ep);
        check("carryout0", {47'h0, carryout0}, {47'h0, eco});
`ifdef DSP_PATTERN_DETECT_EN
        check("pattern_detect0", {47'h0, pd0}, {47'h0, (r && ep == PAT0)});
`endif
    endtask

    localparam logic [W-1:0] ONES = {W{1'b1}};

    initial begin
        rst = 1'b0; cep = 1'b1; opmode_z = 2'd2; x_in = 48'h5; c_in = '0; pcin = '0;
        carryin = 1'b0; sub = 1'b0;
        rst0 = 1'b1; cep0 = 1'b1; opmode_z0 = 2'd0; x_in0 = '0; c_in0 = '0; pcin0 = '0;
        carryin0 = 1'b0; sub0 = 1'b0;
        #1;
        check("reset_p_t0", p, '0);
        check("reset_co_t0", {47'h0, carryout}, '0);

        // Reset held with clock running, then release: p = 5 one edge later
        repeat (3) apply(0, 1, 2'd2, 48'h5, '0, '0, 0, 0, 0);
        apply(1, 1, 2'd2, 48'h5, '0, '0, 0, 0, 0);

        // Accumulate 3 four times from zero, then hold with cep low
        apply(0, 1, 2'd2, 48'h3, '0, '0, 0, 0, 0);
        repeat (4) apply(1, 1, 2'd2, 48'h3, '0, '0, 0, 0, 0);
        repeat (2) apply(1, 0, 2'd2, 48'h3, '0, '0, 0, 0, 0);

        // Wrap, subtract, subtract with borrow
        apply(1, 1, 2'd3, 48'h1, ONES, '0, 0, 0, 0);
        apply(1, 1, 2'd3, 48'h1, ONES, '0, 0, 1, 0);
        apply(1, 1, 2'd3, 48'h5, 48'h2, '0, 1, 1, 0);

        // Reset pulse in mid-accumulation, then resume
        apply(0, 1, 2'd2, 48'h3, '0, '0, 0, 0, 0);
        repeat (3) apply(1, 1, 2'd2, 48'h3, '0, '0, 0, 0, 0);
        apply(1, 1, 2'd2, 48'h3, '0, '0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            apply(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), rnd48(), rnd48(), rnd48(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        // Drain with the stage frozen
        @(negedge clk);
        cep = 1'b0;
        for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
        #3;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        // Combinational instance
        comb(1, 2'd1, 48'd20, '0, 48'd100, 1, 0);
        comb(1, 2'd2, 48'd20, '0, 48'd100, 1, 0);
        comb(0, 2'd1, 48'd20, '0, 48'd100, 1, 0);
        comb(1, 2'd3, 48'h1, ONES, '0, 0, 0);
        comb(1, 2'd3, 48'h5, 48'h2, '0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            comb(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), rnd48(), rnd48(),
                 rnd48(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/dsp_post_adder_acc.md
Name: dsp_post_adder_acc

Overview:
- Post-adder/subtracter and P-output stage of the DSP48A1 slice.
- Sits directly downstream of the per-input pipeline REG_MUX stages (C, carry-in, OPMODE, M).
- Combines the X operand (multiplier product or D:A:B concatenation, selected upstream) with a Z operand (zero, PCIN, P feedback or C) and a carry-in.
- Drives the P register, CARRYOUT and the PCOUT cascade; P feedback provides multiply-accumulate.

Parameters:
- PREG, 1, 1 = P and CARRYOUT registered; 0 = combinational outputs.
- WIDTH, 48, width of X, Z, P and PCOUT.
- PATTERN, 48'h0, compare value for the optional pattern detector.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- cep  in  1  clock enable for P, CARRYOUT and PATTERN_DETECT registers.
- x_in  in  WIDTH  X operand from the upstream M/concat REG_MUX stage.
- c_in  in  WIDTH  C operand from the C REG_MUX stage.
- pcin  in  WIDTH  cascade input from the previous slice.
- opmode_z  in  2  Z select: 0 = zero, 1 = pcin, 2 = P feedback, 3 = c_in.
- sub  in  1  0 = Z + X + CIN; 1 = Z - (X + CIN).
- carryin  in  1  CIN from the carry-in REG_MUX stage.
- p  out  WIDTH  result.
- pcout  out  WIDTH  cascade output; always equal to p.
- carryout  out  1  bit WIDTH of the (WIDTH+1)-bit result.

Behaviour:
- Arithmetic: zero-extend Z and X to WIDTH+1 bits.
  - sum = Z + X + CIN, or Z - X - CIN when sub = 1.
  - p = sum[WIDTH-1:0]; carryout = sum[WIDTH].
  - On subtract, carryout = 1 means borrow.
  - Results wrap modulo 2^WIDTH; there is no saturation.
- PREG = 1 (latency 1 clock):
  - On the rising edge with cep = 1: p, carryout <= new sum.
  - With cep = 0: p and carryout hold.
  - Z select (2 = P feedback) uses the current registered p, giving an accumulator.
- PREG = 0 (latency 0): p and carryout are combinational.
  - opmode_z = 2 is treated as Z = 0, so no combinational loop exists.
- Reset: rst = 0 immediately forces p = 0, pcout = 0, carryout = 0 (and pattern_detect = 0), independent of clk and cep.
  - Reset asserted mid-accumulation discards the running total.
  - First edge after rst returns to 1 with cep = 1 loads the sum computed with P feedback = 0.
- Simultaneous events: reset dominates cep. cep = 0 dominates any opmode_z/sub change.
- Operand changes take effect on the edge that samples them; there is no internal OPMODE register (provided upstream).

Optional Feature:
- Macro: DSP_PATTERN_DETECT_EN.
- Defined:
  - Adds output pattern_detect (1 bit), equal to (next p == PATTERN).
  - With PREG = 1 it is registered under cep alongside p; with PREG = 0 it is combinational.
  - Reset value 0.
- Undefined: port and logic absent; no other behaviour changes.

Test Plan:
- Reset: hold rst = 0 with x_in = 48'h5, cep = 1, clk running -> p = 0, carryout = 0 throughout. Release rst -> p = 5 one edge later (opmode_z = 2, sub = 0, carryin = 0).
- Accumulate: opmode_z = 2, x_in = 3, carryin = 0, cep = 1 for 4 edges from p = 0 -> p = 3, 6, 9, 12 on successive edges. Drop cep for 2 edges -> p stays 12.
- Wrap/carry: opmode_z = 3, c_in = 48'hFFFF_FFFF_FFFF, x_in = 1, carryin = 0 -> p = 0, carryout = 1.
  - Same operands with sub = 1 -> p = 48'hFFFF_FFFF_FFFE, carryout = 0.
- Subtract with borrow: c_in = 2, x_in = 5, carryin = 1, sub = 1 -> p = 48'hFFFF_FFFF_FFFC, carryout = 1. pcout equals p every cycle.
- Reset mid-operation: accumulate to p = 9, pulse rst low for 3 ns between edges -> p = 0 immediately. Next enabled edge -> p = 3.
- PREG = 0 instance: opmode_z = 1, pcin = 100, x_in = 20, carryin = 1 -> p = 121 in the same cycle. opmode_z = 2 -> p = 21. With DSP_PATTERN_DETECT_EN and PATTERN = 121 -> pattern_detect = 1 only while p = 121.
